// File: rtl/que_rr_grant.sv
// -----------------------------------------------------------------------------
// que_rr_grant
// Round-robin grant controller for the queue arbitrator. In IDLE it scans the
// raw request vector starting at a registered pointer. It locks the first
// requester it finds as the grant, and holds that grant frozen in BUSY until
// the granted queue pulses i_done. An optional hold timeout (MAX_HOLD > 0)
// force-releases a grant so that the other queues still make progress.
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_rst           synchronous active-high reset
//   i_req           per-queue level-sensitive request
//   i_done          completion pulse from the granted queue (ignored in IDLE)
//   o_grant_vld     grant active
//   o_grant_sel     binary index of the granted queue (kept after release)
//   o_grant_onehot  one-hot of o_grant_sel while valid, else zero
//   o_timeout       one-cycle pulse when MAX_HOLD force-releases a grant
// -----------------------------------------------------------------------------
module que_rr_grant #(
   parameter int NUM_QUE  = 16,
   parameter int SELW     = $clog2(NUM_QUE),
   parameter int MAX_HOLD = 0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NUM_QUE-1:0]  i_req,
   input  logic                i_done,
   output logic                o_grant_vld,
   output logic [SELW-1:0]     o_grant_sel,
   output logic [NUM_QUE-1:0]  o_grant_onehot,
   output logic                o_timeout
);

   localparam int HOLDW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
   localparam logic [HOLDW-1:0]   HOLD_LAST = HOLD_LAST_I[HOLDW-1:0];
   localparam logic [HOLDW-1:0]   HOLD_MAX  = {HOLDW{1'b1}};
   localparam logic [HOLDW-1:0]   HOLD_ONE  = HOLDW'(1'b1);
   localparam logic [SELW-1:0]    SEL_ONE   = SELW'(1'b1);
   localparam logic [NUM_QUE-1:0] OH_ONE    = NUM_QUE'(1'b1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t               state_r,   state_n;
   logic [SELW-1:0]      ptr_r,     ptr_n;
   logic [HOLDW-1:0]     hold_cnt_r, hold_cnt_n;
   logic                 vld_r,     vld_n;
   logic [SELW-1:0]      sel_r,     sel_n;
   logic [NUM_QUE-1:0]   onehot_r,  onehot_n;
   logic                 timeout_r, timeout_n;

   logic                 pick_found_s;
   logic [SELW-1:0]      pick_idx_s;
   logic [SELW-1:0]      scan_idx_s;
   logic                 scan_hit_s;
   logic                 timeout_hit_s;

   // The timeout fires on the last permitted BUSY edge; it is constant-false when disabled.
   assign timeout_hit_s = (MAX_HOLD > 0) && (hold_cnt_r == HOLD_LAST);

   // Rotated priority scan: the first set request at ptr, ptr+1, ... wrapping mod NUM_QUE.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = {SELW{1'b0}};
      scan_idx_s   = {SELW{1'b0}};
      scan_hit_s   = 1'b0;
      for (int i = 0; i < NUM_QUE; i++) begin
         // SELW-bit addition wraps naturally because NUM_QUE is a power of two.
         scan_idx_s   = ptr_r + i[SELW-1:0];
         scan_hit_s   = !pick_found_s && i_req[scan_idx_s];
         pick_idx_s   = scan_hit_s ? scan_idx_s : pick_idx_s;
         pick_found_s = pick_found_s | scan_hit_s;
      end
   end

   // Next-state and next-output logic for the IDLE/BUSY grant FSM.
   always_comb begin
      state_n    = state_r;
      ptr_n      = ptr_r;
      hold_cnt_n = hold_cnt_r;
      vld_n      = vld_r;
      sel_n      = sel_r;
      onehot_n   = onehot_r;
      timeout_n  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) begin
               vld_n      = 1'b1;
               sel_n      = pick_idx_s;
               onehot_n   = OH_ONE << pick_idx_s;
               hold_cnt_n = {HOLDW{1'b0}};
               state_n    = ST_BUSY;
            end else begin
               state_n    = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (hold_cnt_r != HOLD_MAX) begin
               hold_cnt_n = hold_cnt_r + HOLD_ONE;
            end else begin
               hold_cnt_n = hold_cnt_r;
            end
            // i_done has priority over the timeout, so a coinciding completion
            // releases the grant without a timeout pulse.
            if (i_done || timeout_hit_s) begin
               vld_n     = 1'b0;
               onehot_n  = {NUM_QUE{1'b0}};
               ptr_n     = sel_r + SEL_ONE;
               state_n   = ST_IDLE;
               timeout_n = !i_done;
            end else begin
               state_n   = ST_BUSY;
            end
         end
         default: begin
            state_n  = ST_IDLE;
            vld_n    = 1'b0;
            onehot_n = {NUM_QUE{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ST_IDLE;
         ptr_r      <= {SELW{1'b0}};
         hold_cnt_r <= {HOLDW{1'b0}};
         vld_r      <= 1'b0;
         sel_r      <= {SELW{1'b0}};
         onehot_r   <= {NUM_QUE{1'b0}};
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_n;
         ptr_r      <= ptr_n;
         hold_cnt_r <= hold_cnt_n;
         vld_r      <= vld_n;
         sel_r      <= sel_n;
         onehot_r   <= onehot_n;
         timeout_r  <= timeout_n;
      end
   end

   assign o_grant_vld    = vld_r;
   assign o_grant_sel    = sel_r;
   assign o_grant_onehot = onehot_r;
   assign o_timeout      = timeout_r;

endmodule

// File: tb/tb_que_rr_grant.sv
// -----------------------------------------------------------------------------
// tb_que_rr_grant
// Bench for que_rr_grant. Two instances share the same stimulus: u0 has no
// hold timeout (MAX_HOLD=0), and u1 uses MAX_HOLD=8. A behavioural model keeps
// a grant age and a pointer for each instance. The outputs of both instances
// are compared against this model on every falling edge. Directed steps pin
// the model with literal values, and a randomized phase then exercises the
// rest of the behaviour.
// -----------------------------------------------------------------------------
module tb_que_rr_grant;

   localparam int N  = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          done;
   logic [N-1:0]  req;

   logic          vld0, vld1, to0, to1;
   logic [SW-1:0] sel0, sel1;
   logic [N-1:0]  oh0, oh1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   que_rr_grant #(.NUM_QUE(N), .MAX_HOLD(0)) u0 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
      .o_grant_vld(vld0), .o_grant_sel(sel0), .o_grant_onehot(oh0), .o_timeout(to0)
   );

   que_rr_grant #(.NUM_QUE(N), .MAX_HOLD(8)) u1 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
      .o_grant_vld(vld1), .o_grant_sel(sel1), .o_grant_onehot(oh1), .o_timeout(to1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // For each instance the model keeps: busy, the granted index, the number
   // of cycles the grant has been visible so far, and the next scan start.
   bit m_busy [2];
   int m_sel  [2];
   int m_age  [2];
   int m_ptr  [2];
   bit m_to   [2];
   int m_max  [2] = '{0, 8};
   bit model_ok = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_busy[k] = 1'b0; m_sel[k] = 0; m_age[k] = 0; m_ptr[k] = 0; m_to[k] = 1'b0;
         end else begin
            m_to[k] = 1'b0;
            if (!m_busy[k]) begin
               for (int j = 0; j < N; j++) begin
                  if (req[(m_ptr[k] + j) % N]) begin
                     m_sel[k]  = (m_ptr[k] + j) % N;
                     m_busy[k] = 1'b1;
                     m_age[k]  = 1;
                     break;
                  end
               end
            end else if (done) begin
               m_busy[k] = 1'b0;
               m_ptr[k]  = (m_sel[k] + 1) % N;
            end else if (m_max[k] > 0 && m_age[k] == m_max[k]) begin
               m_busy[k] = 1'b0;
               m_ptr[k]  = (m_sel[k] + 1) % N;
               m_to[k]   = 1'b1;
            end else begin
               m_age[k]  = m_age[k] + 1;
            end
         end
      end
      if (rst) model_ok = 1'b1;
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("u0_vld",    32'(vld0), 32'(m_busy[0]));
         chk("u0_sel",    32'(sel0), 32'(m_sel[0]));
         chk("u0_onehot", 32'(oh0),  m_busy[0] ? (32'd1 << m_sel[0]) : 32'd0);
         chk("u0_timeout",32'(to0),  32'(m_to[0]));
         chk("u1_vld",    32'(vld1), 32'(m_busy[1]));
         chk("u1_sel",    32'(sel1), 32'(m_sel[1]));
         chk("u1_onehot", 32'(oh1),  m_busy[1] ? (32'd1 << m_sel[1]) : 32'd0);
         chk("u1_timeout",32'(to1),  32'(m_to[1]));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cnt, to_cnt, to_fall;
      bit prev;
      rst = 1'b1; req = '0; done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle with no requests.
      repeat (20) begin
         @(negedge clk);
         chk("idle_vld", 32'(vld0), 32'd0);
         chk("idle_onehot", 32'(oh0), 32'd0);
      end

      // Pointer 0, requests 4 and 7.
      req = 16'h0090;
      @(negedge clk);
      chk("rr_first_sel", 32'(sel0), 32'd4);
      chk("rr_first_onehot", 32'(oh0), 32'h0010);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("rr_gap_vld", 32'(vld0), 32'd0);
      @(negedge clk);
      chk("rr_second_vld", 32'(vld0), 32'd1);
      chk("rr_second_sel", 32'(sel0), 32'd7);
      chk("rr_second_onehot", 32'(oh0), 32'h0080);
      done = 1'b1; req = '0;
      @(negedge clk);
      done = 1'b0;

      // Wrap between 15 and 0.
      req = 16'h8001;
      @(negedge clk);
      chk("wrap_sel15", 32'(sel0), 32'd15);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      chk("wrap_sel0", 32'(sel0), 32'd0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      chk("wrap_sel15_again", 32'(sel0), 32'd15);
      done = 1'b1; req = '0;
      @(negedge clk);
      done = 1'b0;

      // Withdrawal of the granted request has no effect while busy.
      req = 16'h0008;
      @(negedge clk);
      req = '0;
      repeat (10) begin
         @(negedge clk);
         chk("withdraw_vld", 32'(vld0), 32'd1);
         chk("withdraw_sel", 32'(sel0), 32'd3);
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("withdraw_after_vld", 32'(vld0), 32'd0);
      end

      // Timeout on u1: grant visible exactly 8 cycles, pulse as vld falls.
      req = 16'h0002;
      @(negedge clk);
      req = '0;
      cnt = 0; to_cnt = 0; to_fall = 0; prev = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (vld1) cnt++;
         if (to1) begin
            to_cnt++;
            if (!vld1 && prev) to_fall++;
         end
         prev = vld1;
         @(negedge clk);
      end
      chk("to_hold_cycles", 32'(cnt), 32'd8);
      chk("to_pulse_count", 32'(to_cnt), 32'd1);
      chk("to_pulse_at_fall", 32'(to_fall), 32'd1);
      req = 16'h0006;
      @(negedge clk);
      chk("to_ptr_next_sel", 32'(sel1), 32'd2);
      done = 1'b1; req = '0;
      @(negedge clk);
      done = 1'b0;

      // i_done on the 8th cycle beats the timeout.
      req = 16'h0002;
      @(negedge clk);
      req = '0;
      for (int c = 1; c <= 8; c++) begin
         chk("nto_vld", 32'(vld1), 32'd1);
         done = (c == 8);
         @(negedge clk);
      end
      done = 1'b0;
      chk("nto_vld_fall", 32'(vld1), 32'd0);
      chk("nto_timeout", 32'(to1), 32'd0);

      // Reset together with i_done in the middle of a grant.
      req = 16'h0020;
      @(negedge clk);
      req = '0;
      chk("rst_pre_sel", 32'(sel0), 32'd5);
      rst = 1'b1; done = 1'b1;
      @(negedge clk);
      rst = 1'b0; done = 1'b0;
      chk("rst_vld", 32'(vld0), 32'd0);
      chk("rst_sel", 32'(sel0), 32'd0);
      req = 16'h0021;
      @(negedge clk);
      chk("rst_next_sel", 32'(sel0), 32'd0);
      chk("rst_next_vld", 32'(vld0), 32'd1);
      req = '0; done = 1'b1;
      @(negedge clk);
      done = 1'b0;

      // Randomized traffic, checked every cycle by the compare process.
      for (int c = 0; c < 4000; c++) begin
         case ($urandom_range(0, 3))
            0:       req = '0;
            1:       req = 16'd1 << $urandom_range(0, N - 1);
            default: req = N'($urandom);
         endcase
         done = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst = 1'b0; req = '0; done = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
